spi_rx_deserializer: RTL and testbench

- Receive-side neighbour of the SPI serializer. Consumes the serializer's own spi_clk and frame-active indication, samples the spi_rx pin on the edge selected by CPOL/CPHA, and assembles words of programmable length.
- Completed words are pushed into an internal first-word-fall-through RX FIFO.
- Provides the RXFE/RXFF/RXFO status bits and the RX data read path for the Avalon register block (DATA_REG read, STATUS_REG W1C).

---
 rtl/spi_rx_deserializer.sv | 152 +++++++++++++++
 tb/tb_spi_rx_deserializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_deserializer.sv
// rtl/spi_rx_deserializer.sv - SPI receive deserializer feeding a first-word-fall-through RX FIFO
module spi_rx_deserializer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [4:0]       word_size,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             frame_active,
  input  logic             spi_clk,
  input  logic             spi_rx,
  input  logic             rd_pulse,
  input  logic             clear_ov,
  output logic [31:0]      rd_data,
  output logic             rxfe,
  output logic             rxff,
  output logic             rxfo,
  output logic [PTR_W:0]   rx_count,
  output logic             rx_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        shreg;
  logic [4:0]         cnt;

  logic               rx_meta;
  logic               rx_sync;
  logic               sclk_d1;
  logic               sclk;
  logic               prev_sclk;
  logic               leading;
  logic               trailing;
  logic               sample;

  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wrptr;
  logic [PTR_W-1:0]   rdptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;
  logic               wr_en;
  logic               full;
  logic               empty;

  // spi_clk takes the same two-flop path as the data so edges and bits stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b0;
      rx_sync   <= 1'b0;
      sclk_d1   <= 1'b0;
      sclk      <= 1'b0;
      prev_sclk <= 1'b0;
    end else begin
      rx_meta   <= spi_rx;
      rx_sync   <= rx_meta;
      sclk_d1   <= spi_clk;
      sclk      <= sclk_d1;
      prev_sclk <= sclk;
    end
  end

  assign leading  = (prev_sclk == cpol) && (sclk != cpol);
  assign trailing = (prev_sclk != cpol) && (sclk == cpol);
  assign sample   = cpha ? trailing : leading;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (frame_active) begin
            state <= SHIFT;
            shreg <= '0;
            cnt   <= word_size;
          end
        end
        SHIFT: begin
          // a frame ending before the last bit drops the partial word
          if (!frame_active) begin
            state <= IDLE;
          end else if (sample) begin
            shreg <= {shreg[30:0], rx_sync};
            if (cnt == 5'd0) state <= PUSH;
            else             cnt   <= cnt - 5'd1;
          end
        end
        PUSH: begin
          if (frame_active) begin
            state <= SHIFT;
            shreg <= '0;
            cnt   <= word_size;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy = (state == SHIFT) || (state == PUSH);

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = (state == PUSH);
  assign pop   = rd_pulse && !empty;
  // a pop in the same cycle frees the slot, so a push while full still lands
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wrptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
      rxfo  <= 1'b0;
    end else begin
      if (wr_en) wrptr <= wrptr + 1'b1;
      if (pop)   rdptr <= rdptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) rxfo <= 1'b1;
      else if (clear_ov)        rxfo <= 1'b0;
    end
  end

  assign rxfe     = empty;
  assign rxff     = full;
  assign rx_count = count;
  assign rd_data  = empty ? 32'd0 : mem[rdptr];

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// tb/tb_spi_rx_deserializer.sv - self-checking bench for spi_rx_deserializer against a queue model
module tb_spi_rx_deserializer;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int HALF  = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [4:0]       word_size;
  logic             cpol;
  logic             cpha;
  logic             frame_active;
  logic             spi_clk;
  logic             spi_rx;
  logic             rd_pulse;
  logic             clear_ov;
  logic [31:0]      rd_data;
  logic             rxfe;
  logic             rxff;
  logic             rxfo;
  logic [PTR_W:0]   rx_count;
  logic             rx_busy;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [31:0]      exp_q[$];
  logic             exp_ov;
  logic [31:0]      tx_q[$];

  spi_rx_deserializer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .word_size(word_size),
    .cpol(cpol), .cpha(cpha), .frame_active(frame_active), .spi_clk(spi_clk),
    .spi_rx(spi_rx), .rd_pulse(rd_pulse), .clear_ov(clear_ov), .rd_data(rd_data),
    .rxfe(rxfe), .rxff(rxff), .rxfo(rxfo), .rx_count(rx_count), .rx_busy(rx_busy)
  );

  always #10 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz = exp_q.size();
    chk({tag, ".count"}, 32'(rx_count), 32'(sz));
    chk({tag, ".rxfe"},  32'(rxfe), 32'(sz == 0));
    chk({tag, ".rxff"},  32'(rxff), 32'(sz == DEPTH));
    chk({tag, ".rxfo"},  32'(rxfo), 32'(exp_ov));
    chk({tag, ".data"},  rd_data, (sz == 0) ? 32'd0 : exp_q[0]);
  endtask

  function automatic logic [31:0] mask_of(input logic [4:0] ws);
    logic [63:0] m = (64'd1 << (int'(ws) + 1)) - 64'd1;
    return m[31:0];
  endfunction

  task automatic half(input bit pop);
    for (int i = 0; i < HALF; i++) begin
      rd_pulse = pop && (i == 3);
      @(negedge clk);
    end
    rd_pulse = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic [4:0] ws, input int nbits, input bit pop);
    for (int i = 0; i < nbits; i++) begin
      bit last = (i == nbits - 1);
      if (!cpha) begin
        spi_rx = data[int'(ws) - i];
        half(1'b0);
        spi_clk = ~cpol;
        half(pop && last);
        spi_clk = cpol;
      end else begin
        spi_clk = ~cpol;
        spi_rx = data[int'(ws) - i];
        half(1'b0);
        spi_clk = cpol;
        half(pop && last);
      end
    end
    if (nbits == int'(ws) + 1 && enable) begin
      if (pop) begin
        void'(exp_q.pop_front());
        exp_q.push_back(data & mask_of(ws));
      end else if (exp_q.size() < DEPTH) begin
        exp_q.push_back(data & mask_of(ws));
      end else begin
        exp_ov = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input logic [4:0] ws, input int last_bits, input bit pop_last);
    word_size = ws;
    spi_clk = cpol;
    repeat (4) @(negedge clk);
    frame_active = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < tx_q.size(); k++) begin
      bit is_last = (k == tx_q.size() - 1);
      send_word(tx_q[k], ws, is_last ? last_bits : int'(ws) + 1, pop_last && is_last);
    end
    repeat (6) @(negedge clk);
    frame_active = 1'b0;
    repeat (4) @(negedge clk);
    tx_q.delete();
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      check_state(tag);
      rd_pulse = 1'b1;
      @(negedge clk);
      rd_pulse = 1'b0;
      void'(exp_q.pop_front());
    end
    check_state({tag, ".empty"});
  endtask

  initial begin
    logic [4:0] ws;
    reset = 1'b1; enable = 1'b1; word_size = 5'd7; cpol = 1'b0; cpha = 1'b0;
    frame_active = 1'b0; spi_clk = 1'b0; spi_rx = 1'b0; rd_pulse = 1'b0; clear_ov = 1'b0;
    exp_ov = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_state("reset");
    chk("reset.busy", 32'(rx_busy), 32'd0);

    tx_q.push_back(32'hA5);
    run_frame(5'd7, 8, 1'b0);
    check_state("mode0");
    chk("mode0.a5", rd_data, 32'h0000_00A5);
    drain("mode0");

    for (int m = 1; m < 4; m++) begin
      cpol = m[1]; cpha = m[0];
      tx_q.push_back(32'h3C);
      run_frame(5'd7, 8, 1'b0);
      chk($sformatf("mode%0d.3c", m), rd_data, 32'h3C);
      drain($sformatf("mode%0d", m));
    end

    cpol = 1'b0; cpha = 1'b0;
    tx_q.push_back(32'hDEADBEEF);
    run_frame(5'd31, 32, 1'b0);
    chk("ws31", rd_data, 32'hDEADBEEF);
    drain("ws31");
    tx_q.push_back(32'hB);
    run_frame(5'd3, 4, 1'b0);
    chk("ws3", rd_data, 32'h0000_000B);
    drain("ws3");

    for (int i = 0; i < 17; i++) tx_q.push_back(32'(i));
    run_frame(5'd7, 8, 1'b0);
    check_state("ovf");
    chk("ovf.rxfo", 32'(rxfo), 32'd1);
    drain("ovf");
    clear_ov = 1'b1;
    @(negedge clk);
    clear_ov = 1'b0;
    exp_ov = 1'b0;
    check_state("clear_ov");
    rd_pulse = 1'b1;
    @(negedge clk);
    rd_pulse = 1'b0;
    check_state("pop_empty");

    for (int i = 0; i < 16; i++) tx_q.push_back(32'h20 + 32'(i));
    run_frame(5'd7, 8, 1'b0);
    check_state("full");
    tx_q.push_back(32'h99);
    run_frame(5'd7, 8, 1'b1);
    check_state("pushpop_full");
    chk("pushpop_full.tail", exp_q[DEPTH-1], 32'h99);
    drain("pushpop_full");

    tx_q.push_back(32'hF0);
    run_frame(5'd7, 4, 1'b0);
    check_state("abort");

    enable = 1'b0;
    tx_q.push_back(32'h5A);
    run_frame(5'd7, 8, 1'b0);
    check_state("disabled");
    enable = 1'b1;

    for (int i = 0; i < 3; i++) tx_q.push_back(32'h70 + 32'(i));
    run_frame(5'd7, 8, 1'b0);
    check_state("pre_reset");
    frame_active = 1'b1;
    repeat (3) @(negedge clk);
    send_word(32'hFF, 5'd7, 3, 1'b0);
    reset = 1'b1;
    frame_active = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_ov = 1'b0;
    check_state("mid_reset");
    chk("mid_reset.busy", 32'(rx_busy), 32'd0);

    for (int r = 0; r < 6; r++) begin
      int n;
      cpol = 1'($urandom_range(0, 1));
      cpha = 1'($urandom_range(0, 1));
      ws = 5'($urandom_range(0, 31));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) tx_q.push_back($urandom);
      run_frame(ws, int'(ws) + 1, 1'b0);
      drain($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
